// File: rtl/grf_scoreboard_pkg.sv
// rtl/grf_scoreboard_pkg.sv - shared GRF scoreboard constants and types
package grf_scoreboard_pkg;
    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;
    localparam int CNT_W        = 2;
    localparam int MAX_INFLIGHT = 8;
    localparam int INFLIGHT_W   = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/grf_scoreboard_if.sv
// rtl/grf_scoreboard_if.sv - issue/write-back/query bundle between pipeline and scoreboard
interface grf_scoreboard_if;
    import grf_scoreboard_pkg::*;

    logic                  issue_valid;
    reg_addr_t             issue_A3;
    logic                  issue_ready;
    logic                  wb_WE;
    reg_addr_t             wb_A3;
    reg_addr_t             A1;
    reg_addr_t             A2;
    logic                  busy1;
    logic                  busy2;
    logic                  stall;
    logic [INFLIGHT_W-1:0] inflight;
    logic                  wb_err;

    modport master (
        output issue_valid, issue_A3, wb_WE, wb_A3, A1, A2,
        input  issue_ready, busy1, busy2, stall, inflight, wb_err
    );

    modport slave (
        input  issue_valid, issue_A3, wb_WE, wb_A3, A1, A2,
        output issue_ready, busy1, busy2, stall, inflight, wb_err
    );
endinterface

// File: rtl/grf_scoreboard_sb_counter.sv
// rtl/grf_scoreboard_sb_counter.sv - per-register saturating pending-write counter
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero,
    output logic             o_full
);
    logic [CNT_W-1:0] r_cnt;

    // Simultaneous inc and dec cancel; the flags keep the count inside 0..max.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && !o_full) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc && !o_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = ~|r_cnt;
    assign o_full = &r_cnt;
endmodule

// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - pending-write scoreboard for the 32-entry GRF
module grf_scoreboard #(
    parameter int NUM_REGS     = grf_scoreboard_pkg::NUM_REGS,
    parameter int CNT_W        = grf_scoreboard_pkg::CNT_W,
    parameter int MAX_INFLIGHT = grf_scoreboard_pkg::MAX_INFLIGHT
) (
    input  logic                     clk,
    input  logic                     reset,
    grf_scoreboard_if.slave          bus
);
    import grf_scoreboard_pkg::*;

    logic [CNT_W-1:0]      w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0]   w_inc;
    logic [NUM_REGS-1:0]   w_dec;
    logic [NUM_REGS-1:0]   w_zero;
    logic [NUM_REGS-1:0]   w_full;
    logic [INFLIGHT_W-1:0] r_inflight;
    logic                  r_wb_err;
    logic                  w_accept;
    logic                  w_wb_hit;
    logic                  w_release;

    // Register 0 is hardwired to zero, so it is never pending.
    assign w_cnt[0]  = '0;
    assign w_zero[0] = 1'b1;
    assign w_full[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .i_inc  (w_inc[i]),
            .i_dec  (w_dec[i]),
            .o_cnt  (w_cnt[i]),
            .o_zero (w_zero[i]),
            .o_full (w_full[i])
        );
    end

    assign bus.issue_ready = (bus.issue_A3 == REG_ZERO) |
                             (!w_full[bus.issue_A3] && r_inflight != INFLIGHT_W'(MAX_INFLIGHT));

    assign w_accept  = bus.issue_valid & bus.issue_ready & (bus.issue_A3 != REG_ZERO);
    assign w_wb_hit  = bus.wb_WE & (bus.wb_A3 != REG_ZERO);
    assign w_release = w_wb_hit & ~w_zero[bus.wb_A3];

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        w_inc[bus.issue_A3] = w_accept;
        w_dec[bus.wb_A3]    = w_release;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            if (w_accept && !w_release) begin
                r_inflight <= r_inflight + INFLIGHT_W'(1);
            end else if (!w_accept && w_release) begin
                r_inflight <= r_inflight - INFLIGHT_W'(1);
            end
            if (w_wb_hit && w_zero[bus.wb_A3]) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    // Busy looks only at registered counts: a same-cycle write-back lands at the edge.
    assign bus.busy1    = (bus.A1 != REG_ZERO) && (w_cnt[bus.A1] != '0);
    assign bus.busy2    = (bus.A2 != REG_ZERO) && (w_cnt[bus.A2] != '0);
    assign bus.stall    = bus.busy1 | bus.busy2;
    assign bus.inflight = r_inflight;
    assign bus.wb_err   = r_wb_err;
endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Tracks in-flight writes to the 32-entry general register file on behalf of its readers.
- Issue side reserves a destination register. Write-back side releases it on the same strobe that drives the GRF write enable.
- Decode side queries two source addresses and gets busy flags plus a stall request.
- Sits between decode/issue and write-back so that multi-cycle producers (mult/div, loads) never hand stale register values to readers.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is never tracked.
- CNT_W, 2, width of the per-register pending counter; at most 2**CNT_W-1 = 3 in-flight writes per register.
- MAX_INFLIGHT, 8, global cap on outstanding reservations across all registers.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issue stage requests a reservation this cycle.
- issue_A3  in  5  destination register to reserve.
- issue_ready  out  1  reservation accepted this cycle (handshake with issue_valid).
- wb_WE  in  1  write-back strobe; same signal as the GRF write enable.
- wb_A3  in  5  register being written back.
- A1  in  5  source address 1 under query.
- A2  in  5  source address 2 under query.
- busy1  out  1  A1 has a pending write.
- busy2  out  1  A2 has a pending write.
- stall  out  1  busy1 | busy2.
- inflight  out  4  total outstanding reservations, 0..MAX_INFLIGHT.
- wb_err  out  1  sticky; set by a write-back with no matching reservation.

Behaviour:
- Reset (reset low, asynchronous): all counters clear to 0, inflight=0, wb_err=0. Therefore busy1=busy2=stall=0 and issue_ready=1 while reset is deasserted with an empty state.
- Reset mid-operation discards every reservation immediately. Late write-backs arriving after reset set wb_err.
- State: cnt[1..31] of CNT_W bits each, plus the inflight counter. cnt[0] is constant 0.
- issue_ready (combinational, from registered state only) = (issue_A3==0) | (cnt[issue_A3] != 3 && inflight != MAX_INFLIGHT).
  - A write-back in the same cycle does not raise issue_ready (no bypass).
- Accept = issue_valid & issue_ready.
  - If issue_A3 != 0: cnt[issue_A3] += 1 and inflight += 1 at the next edge.
  - If issue_A3 == 0: the issue is accepted with no state change.
- Release = wb_WE & wb_A3 != 0.
  - If cnt[wb_A3] != 0: cnt[wb_A3] -= 1 and inflight -= 1.
  - If cnt[wb_A3] == 0: the counter stays 0, and wb_err is set and held until reset.
  - wb_A3 == 0 is ignored silently.
- Simultaneous accept and release on the same register: net cnt and inflight are unchanged. This is legal even when cnt == 3, but issue_ready is still 0 in that case, so the accept cannot occur.
- Simultaneous accept and release on different registers: each counter updates independently; inflight is unchanged.
- busy1 = (A1 != 0) & (cnt[A1] != 0), using registered counts only. A write-back in the current cycle does not clear busy, because the GRF write lands at that same edge. busy2 is identical for A2.
- Latency: a reservation is visible on busy 1 cycle after acceptance. A release clears busy 1 cycle after the wb_WE cycle.
- All counter arithmetic is unsigned. No wrap-around occurs: the issue_ready guard and the zero-floor on release prevent both overflow and underflow.

Decomposition:
- Shared package holds:
  - REG_ADDR_W = 5 and NUM_REGS = 32;
  - the register-0 constant;
  - CNT_W and MAX_INFLIGHT defaults, shared with the GRF and the hazard/forwarding logic.
- One natural sub-module, sb_counter: a single saturating up/down counter with inc, dec and the zero/full flags. Generate 31 instances; the top holds the inflight counter, wb_err and the read muxes.

Test Plan:
- Reset: drive reset low with clk idle -> busy1=busy2=stall=0, inflight=0, wb_err=0, issue_ready=1.
- Basic hazard: issue $5 at cycle 0; set A1=5 -> busy1=1, stall=1 from cycle 1. wb_WE with wb_A3=5 at cycle 3 -> busy1=1 during cycle 3, 0 from cycle 4, inflight back to 0.
- Per-register saturation: issue $7 three times -> cnt=3 and issue_ready=0 for issue_A3=7. Issue $8 is still accepted -> inflight=4. One write-back of $7 -> issue_ready=1 for $7 on the next cycle.
- Global cap: issue $1..$8 -> inflight=8, issue_ready=0 for $9. Issue_A3=0 is still accepted, and inflight stays 8.
- Simultaneous events: with cnt[$3]=1, issue $3 and write back $3 in the same cycle -> cnt[$3]=1, inflight unchanged, busy on A1=3 stays 1.
- Error and async reset: write back $12 with no reservation -> wb_err=1 next cycle and sticky. Pulse reset low mid-cycle with 5 reservations outstanding -> inflight=0 and wb_err=0 immediately, without waiting for a clock edge.
